// File: rtl/serial_parity_checker.sv
// Serial frame receiver: deserialises DATA_W data bits (LSB first) plus one parity bit,
// then presents the word and a parity-error flag with a one-cycle valid pulse.
module serial_parity_checker #(
    parameter int DATA_W     = 8,
    parameter int ODD_PARITY = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              x,
    input  logic              bit_valid,
    input  logic              frame_start,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              parity_err,
    output logic              frame_abort,
    output logic              busy
);

    localparam int   CNT_W    = $clog2(DATA_W + 1);
    localparam logic ODD_BIT  = (ODD_PARITY != 0);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } state_t;

    state_t            state, state_n;
    logic [DATA_W-1:0] shreg, shreg_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic              acc, acc_n;
    logic [DATA_W-1:0] data_out_n;
    logic              data_valid_n, parity_err_n, frame_abort_n;

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            shreg       <= '0;
            cnt         <= '0;
            acc         <= 1'b0;
            data_out    <= '0;
            data_valid  <= 1'b0;
            parity_err  <= 1'b0;
            frame_abort <= 1'b0;
        end else begin
            state       <= state_n;
            shreg       <= shreg_n;
            cnt         <= cnt_n;
            acc         <= acc_n;
            data_out    <= data_out_n;
            data_valid  <= data_valid_n;
            parity_err  <= parity_err_n;
            frame_abort <= frame_abort_n;
        end
    end

    // Bits enter at the MSB and shift down, so after DATA_W accepted bits
    // the first (LSB-first) bit sits at position 0.
    always_comb begin
        state_n       = state;
        shreg_n       = shreg;
        cnt_n         = cnt;
        acc_n         = acc;
        data_out_n    = data_out;
        data_valid_n  = 1'b0;
        parity_err_n  = parity_err;
        frame_abort_n = 1'b0;
        if (bit_valid) begin
            if (frame_start) begin
                // A restart wins over everything, including a pending parity bit.
                frame_abort_n = (state != IDLE);
                state_n       = DATA;
                shreg_n       = {x, shreg[DATA_W-1:1]};
                cnt_n         = CNT_W'(1);
                acc_n         = x;
            end else begin
                case (state)
                    DATA: begin
                        shreg_n = {x, shreg[DATA_W-1:1]};
                        acc_n   = acc ^ x;
                        cnt_n   = cnt + CNT_W'(1);
                        if (cnt == LAST_IDX) state_n = PARITY;
                    end
                    PARITY: begin
                        data_out_n   = shreg;
                        parity_err_n = acc ^ x ^ ODD_BIT;
                        data_valid_n = 1'b1;
                        cnt_n        = '0;
                        acc_n        = 1'b0;
                        state_n      = IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_serial_parity_checker.sv
// Bench for serial_parity_checker: even and odd instances share one stimulus stream;
// a scoreboard per instance holds expected words/errors, checked on each data_valid.
module tb_serial_parity_checker;

    localparam int DATA_W = 8;

    logic clock = 1'b0;
    logic reset, x, bit_valid, frame_start;
    logic [DATA_W-1:0] e_data, o_data;
    logic e_dv, e_err, e_abort, e_busy;
    logic o_dv, o_err, o_abort, o_busy;

    serial_parity_checker #(.DATA_W(DATA_W), .ODD_PARITY(0)) u_even (
        .clock(clock), .reset(reset), .x(x), .bit_valid(bit_valid), .frame_start(frame_start),
        .data_out(e_data), .data_valid(e_dv), .parity_err(e_err), .frame_abort(e_abort), .busy(e_busy));

    serial_parity_checker #(.DATA_W(DATA_W), .ODD_PARITY(1)) u_odd (
        .clock(clock), .reset(reset), .x(x), .bit_valid(bit_valid), .frame_start(frame_start),
        .data_out(o_data), .data_valid(o_dv), .parity_err(o_err), .frame_abort(o_abort), .busy(o_busy));

    always #5 clock = ~clock;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              err;
    } exp_t;

    exp_t q_even[$];
    exp_t q_odd[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   dv_cnt = 0, abort_cnt = 0, busy_cnt = 0;
    int   dv_cyc[$];

    always @(posedge clock) cyc <= cyc + 1;

    // Scoreboard side: compare every data_valid against the oldest expectation.
    always @(negedge clock) begin
        exp_t e;
        if (e_busy) busy_cnt++;
        if (e_abort) abort_cnt++;
        if (e_dv) begin
            dv_cnt++;
            dv_cyc.push_back(cyc);
            tests++;
            if (q_even.size() == 0) begin
                fails++;
                $display("FAIL even_unexpected_dv: got data=%h err=%b, required no pulse", e_data, e_err);
            end else begin
                e = q_even.pop_front();
                if ({e_data, e_err} !== {e.data, e.err}) begin
                    fails++;
                    $display("FAIL even_frame: got data=%h err=%b, required data=%h err=%b",
                             e_data, e_err, e.data, e.err);
                end
            end
        end
        if (o_dv) begin
            tests++;
            if (q_odd.size() == 0) begin
                fails++;
                $display("FAIL odd_unexpected_dv: got data=%h err=%b, required no pulse", o_data, o_err);
            end else begin
                e = q_odd.pop_front();
                if ({o_data, o_err} !== {e.data, e.err}) begin
                    fails++;
                    $display("FAIL odd_frame: got data=%h err=%b, required data=%h err=%b",
                             o_data, o_err, e.data, e.err);
                end
            end
        end
    end

    task automatic drive_bit(input logic b, input logic fs);
        bit_valid = 1'b1; x = b; frame_start = fs;
        @(posedge clock); #1;
        bit_valid = 1'b0; frame_start = 1'b0; x = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Expectations are pushed as the parity bit is driven.
    task automatic send_frame(input logic [DATA_W-1:0] d, input logic p, input int gap_max);
        exp_t e;
        for (int i = 0; i < DATA_W; i++) begin
            drive_bit(d[i], i == 0);
            if (gap_max > 0) idle($urandom_range(1, gap_max));
        end
        e.data = d;
        e.err  = (^d) ^ p;
        q_even.push_back(e);
        e.err  = ~((^d) ^ p);
        q_odd.push_back(e);
        drive_bit(p, 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b1; x = 1'b0; bit_valid = 1'b0; frame_start = 1'b0;
        idle(3);
        tests++;
        if ({e_data, e_dv, e_err, e_abort, e_busy, o_data, o_dv, o_err, o_abort, o_busy} !== '0) begin
            fails++;
            $display("FAIL reset_state: got even=%h/%b%b%b%b odd=%h/%b%b%b%b, required all zero",
                     e_data, e_dv, e_err, e_abort, e_busy, o_data, o_dv, o_err, o_abort, o_busy);
        end
        reset = 1'b0;
        idle(1);
    endtask

    task automatic test_basic();
        int dv0;
        dv0 = dv_cnt;
        busy_cnt = 0;
        send_frame(8'hA5, 1'b0, 0);
        // outputs registered at the parity edge: visible now
        tests++;
        if ({e_dv, e_data, e_err} !== {1'b1, 8'hA5, 1'b0}) begin
            fails++;
            $display("FAIL basic_latency: got dv=%b data=%h err=%b, required dv=1 data=a5 err=0",
                     e_dv, e_data, e_err);
        end
        idle(3);
        // state is DATA/PARITY from the bit-0 edge up to the parity edge
        tests++;
        if (busy_cnt !== DATA_W) begin
            fails++;
            $display("FAIL basic_busy_cycles: got %0d, required %0d", busy_cnt, DATA_W);
        end
        tests++;
        if ({dv_cnt - dv0, e_dv, e_data} !== {32'd1, 1'b0, 8'hA5}) begin
            fails++;
            $display("FAIL basic_pulse_hold: got pulses=%0d dv=%b data=%h, required 1/0/a5",
                     dv_cnt - dv0, e_dv, e_data);
        end
    endtask

    task automatic test_parity_err();
        send_frame(8'hA5, 1'b1, 0);
        idle(2);
        tests++;
        if ({e_err, o_err} !== 2'b10) begin
            fails++;
            $display("FAIL parity_err_hold: got even=%b odd=%b, required even=1 odd=0", e_err, o_err);
        end
        send_frame(8'h07, 1'b0, 0);
        idle(2);
        tests++;
        if ({e_err, o_err} !== 2'b10) begin
            fails++;
            $display("FAIL odd_parity_07: got even=%b odd=%b, required even=1 odd=0", e_err, o_err);
        end
    endtask

    task automatic test_gaps();
        int dv0;
        dv0 = dv_cnt;
        send_frame(8'h3C, 1'b0, 3);
        idle(4);
        tests++;
        if (dv_cnt - dv0 !== 1) begin
            fails++;
            $display("FAIL gaps_pulse_count: got %0d, required 1", dv_cnt - dv0);
        end
    endtask

    task automatic test_abort();
        int dv0, ab0;
        logic [4:0] junk;
        dv0 = dv_cnt; ab0 = abort_cnt;
        junk = 5'b10110;
        for (int i = 0; i < 5; i++) drive_bit(junk[i], i == 0);
        bit_valid = 1'b1; x = 1'b1; frame_start = 1'b1;
        @(posedge clock); #1;
        tests++;
        if ({e_abort, o_abort, e_busy} !== 3'b111) begin
            fails++;
            $display("FAIL abort_pulse: got even=%b odd=%b busy=%b, required 1/1/1", e_abort, o_abort, e_busy);
        end
        bit_valid = 1'b0; frame_start = 1'b0;
        // the restart bit was data bit 0 of 0xFF; finish that frame
        for (int i = 1; i < DATA_W; i++) drive_bit(1'b1, 1'b0);
        q_even.push_back('{data: 8'hFF, err: 1'b0});
        q_odd.push_back('{data: 8'hFF, err: 1'b1});
        drive_bit(1'b0, 1'b0);
        idle(2);
        tests++;
        if ({dv_cnt - dv0, abort_cnt - ab0} !== {32'd1, 32'd1}) begin
            fails++;
            $display("FAIL abort_counts: got dv=%0d abort=%0d, required 1/1", dv_cnt - dv0, abort_cnt - ab0);
        end
    endtask

    task automatic test_reset_mid();
        int dv0, ab0;
        dv0 = dv_cnt; ab0 = abort_cnt;
        for (int i = 0; i < 4; i++) drive_bit(1'b1, i == 0);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        tests++;
        if ({e_data, e_dv, e_err, e_abort, e_busy, o_err} !== '0) begin
            fails++;
            $display("FAIL reset_mid_state: got data=%h dv=%b err=%b abort=%b busy=%b oerr=%b, required all zero",
                     e_data, e_dv, e_err, e_abort, e_busy, o_err);
        end
        idle(2);
        tests++;
        if ({dv_cnt - dv0, abort_cnt - ab0} !== {32'd0, 32'd0}) begin
            fails++;
            $display("FAIL reset_mid_pulses: got dv=%0d abort=%0d, required 0/0", dv_cnt - dv0, abort_cnt - ab0);
        end
        send_frame(8'h81, 1'b0, 0);
        idle(2);
        tests++;
        if ({e_data, e_err} !== {8'h81, 1'b0}) begin
            fails++;
            $display("FAIL reset_mid_next: got data=%h err=%b, required 81/0", e_data, e_err);
        end
    endtask

    task automatic test_back_to_back();
        int dv0, n0;
        dv0 = dv_cnt;
        for (int i = 0; i < 3; i++) drive_bit(1'b1, 1'b0);
        tests++;
        if ({dv_cnt - dv0, e_busy} !== {32'd0, 1'b0}) begin
            fails++;
            $display("FAIL idle_ignore: got dv=%0d busy=%b, required 0/0", dv_cnt - dv0, e_busy);
        end
        n0 = dv_cyc.size();
        send_frame(8'h01, 1'b1, 0);
        send_frame(8'h02, 1'b0, 0);
        idle(3);
        tests++;
        if (dv_cyc.size() - n0 !== 2) begin
            fails++;
            $display("FAIL b2b_pulse_count: got %0d, required 2", dv_cyc.size() - n0);
        end else begin
            tests++;
            if (dv_cyc[n0+1] - dv_cyc[n0] !== DATA_W + 1) begin
                fails++;
                $display("FAIL b2b_spacing: got %0d, required %0d", dv_cyc[n0+1] - dv_cyc[n0], DATA_W + 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity_err();
        test_gaps();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        tests++;
        if (q_even.size() + q_odd.size() !== 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", q_even.size() + q_odd.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "timeout");
    end

endmodule
